// File: rtl/seq_det_param.sv
// seq_det_param: parameterised serial pattern detector.
// Shifts accepted bits into a PAT_W-deep history, raises a registered
// one-cycle o_det on a match, and keeps a saturating match count.
// Overlapping / non-overlapping detection is selectable per match.
module seq_det_param #(
    parameter int                PAT_W   = 4,
    parameter int                CNT_W   = 8,
    parameter logic [PAT_W-1:0]  RST_PAT = 4'b1011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_seq,
    input  logic             i_valid,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic             i_load,
    input  logic             i_overlap,
    input  logic             i_clr_cnt,
    output logic             o_det,
    output logic [CNT_W-1:0] o_match_cnt,
    output logic [PAT_W-1:0] o_pattern
);

    localparam int               FILL_W  = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;

    logic [PAT_W-1:0]  hist_nxt;
    logic [FILL_W-1:0] fill_inc;
    logic              match;

    // Candidate history/fill if this edge accepts a bit, and the match decision.
    // A load on the same edge discards the bit, so it also suppresses the match.
    always_comb begin
        hist_nxt = {hist[PAT_W-2:0], i_seq};
        fill_inc = (fill == FULL) ? fill : fill + 1'b1;
        match    = i_valid && !i_load && (fill_inc == FULL) && (hist_nxt == o_pattern);
    end

    // History, fill count, active pattern and detect pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist      <= '0;
            fill      <= '0;
            o_det     <= 1'b0;
            o_pattern <= RST_PAT;
        end else if (i_load) begin
            o_pattern <= i_pattern;
            fill      <= '0;
            o_det     <= 1'b0;
        end else if (i_valid) begin
            hist  <= hist_nxt;
            // Non-overlapping mode starts a fresh window after each match.
            fill  <= (match && !i_overlap) ? '0 : fill_inc;
            o_det <= match;
        end else begin
            o_det <= 1'b0;
        end
    end

    // Saturating match counter; clear has priority over a same-edge match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_match_cnt <= '0;
        end else if (i_clr_cnt) begin
            o_match_cnt <= '0;
        end else if (match && (o_match_cnt != CNT_MAX)) begin
            o_match_cnt <= o_match_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_det_param.sv
// Directed bench for seq_det_param: a vector table with a small expected-count
// model, plus hand-written reset sequences. A second instance with CNT_W=2
// shares the stimulus to exercise counter saturation.
module tb_seq_det_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_seq, i_valid, i_load, i_overlap, i_clr_cnt;
    logic [3:0] i_pattern;

    logic       o_det, o_det2;
    logic [7:0] o_cnt;
    logic [1:0] o_cnt2;
    logic [3:0] o_pat, o_pat2;

    always #5 clk = ~clk;

    seq_det_param #(.PAT_W(4), .CNT_W(8), .RST_PAT(4'b1011)) dut (
        .clk(clk), .rst(rst), .i_seq(i_seq), .i_valid(i_valid),
        .i_pattern(i_pattern), .i_load(i_load), .i_overlap(i_overlap),
        .i_clr_cnt(i_clr_cnt), .o_det(o_det), .o_match_cnt(o_cnt),
        .o_pattern(o_pat)
    );

    seq_det_param #(.PAT_W(4), .CNT_W(2), .RST_PAT(4'b1011)) dut2 (
        .clk(clk), .rst(rst), .i_seq(i_seq), .i_valid(i_valid),
        .i_pattern(i_pattern), .i_load(i_load), .i_overlap(i_overlap),
        .i_clr_cnt(i_clr_cnt), .o_det(o_det2), .o_match_cnt(o_cnt2),
        .o_pattern(o_pat2)
    );

    typedef struct {
        logic       seq, valid, load;
        logic [3:0] pat;
        logic       ovl, clr;
        logic       det;
        logic [7:0] cnt;
        logic [1:0] cnt2;
        logic [3:0] epat;
    } vec_t;

    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;

    // expected-state model used while building the table
    int         m_cnt  = 0;
    int         m_cnt2 = 0;
    logic [3:0] m_pat  = 4'b1011;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic seq, input logic valid, input logic load,
                       input logic [3:0] pat, input logic ovl, input logic clr,
                       input logic det);
        vec_t v;
        if (load) m_pat = pat;
        if (clr) begin
            m_cnt  = 0;
            m_cnt2 = 0;
        end else if (det) begin
            m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        v.seq = seq; v.valid = valid; v.load = load; v.pat = pat;
        v.ovl = ovl; v.clr = clr; v.det = det;
        v.cnt = 8'(m_cnt); v.cnt2 = 2'(m_cnt2); v.epat = m_pat;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic seq, input logic valid, input logic load,
                         input logic [3:0] pat, input logic ovl, input logic clr);
        i_seq = seq; i_valid = valid; i_load = load;
        i_pattern = pat; i_overlap = ovl; i_clr_cnt = clr;
    endtask

    initial begin
        logic [15:0] s;
        logic [3:0]  g;
        logic [6:0]  r;

        // ---------------- table construction ----------------
        s = 16'b1011011010110110;
        // overlapping: pulses after bits 4, 7, 12, 15
        for (int i = 0; i < 16; i++)
            add(s[15-i], 1, 0, 4'h0, 1, 0, (i == 3 || i == 6 || i == 11 || i == 14));
        // reload same pattern, clear count; the bit on this edge is discarded
        add(1, 1, 1, 4'b1011, 1, 1, 0);
        // non-overlapping: pulses after bits 4 and 12
        for (int i = 0; i < 16; i++)
            add(s[15-i], 1, 0, 4'h0, 0, 0, (i == 3 || i == 11));
        add(0, 0, 1, 4'b1011, 1, 1, 0);
        // gaps of 3 invalid cycles between bits 1,0,1,1
        g = 4'b1011;
        for (int b = 0; b < 4; b++) begin
            add(g[3-b], 1, 0, 4'h0, 1, 0, (b == 3));
            if (b < 3)
                for (int k = 0; k < 3; k++) add(1, 0, 0, 4'h0, 1, 0, 0);
        end
        add(1, 0, 0, 4'h0, 1, 0, 0);
        // reload mid-stream: 101, load 0110 (bit discarded), then 1,0,1,1,0
        add(0, 0, 1, 4'b1011, 1, 1, 0);
        add(1, 1, 0, 4'h0, 1, 0, 0);
        add(0, 1, 0, 4'h0, 1, 0, 0);
        add(1, 1, 0, 4'h0, 1, 0, 0);
        add(1, 1, 1, 4'b0110, 1, 0, 0);
        add(1, 1, 0, 4'h0, 1, 0, 0);
        add(0, 1, 0, 4'h0, 1, 0, 0);
        add(1, 1, 0, 4'h0, 1, 0, 0);
        add(1, 1, 0, 4'h0, 1, 0, 0);
        add(0, 1, 0, 4'h0, 1, 0, 1);
        // saturation: pattern 1111, eight 1s -> 5 overlapping matches
        add(0, 0, 1, 4'b1111, 1, 1, 0);
        for (int k = 0; k < 8; k++) add(1, 1, 0, 4'h0, 1, 0, (k >= 3));
        // clear on a matching edge: det still pulses, count 0
        add(1, 1, 0, 4'h0, 1, 1, 1);
        add(1, 1, 0, 4'h0, 1, 0, 1);

        // ---------------- reset ----------------
        rst = 1'b1;
        drive(0, 0, 0, 4'h0, 1, 0);
        #12;
        chk("rst det",  32'(o_det),  0);
        chk("rst cnt",  32'(o_cnt),  0);
        chk("rst cnt2", 32'(o_cnt2), 0);
        chk("rst pat",  32'(o_pat),  32'hB);
        #8 rst = 1'b0;   // released at t=20, between edges

        // ---------------- table ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].seq, tbl[i].valid, tbl[i].load, tbl[i].pat, tbl[i].ovl, tbl[i].clr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d det", i),  32'(o_det),  32'(tbl[i].det));
            chk($sformatf("v%0d cnt", i),  32'(o_cnt),  32'(tbl[i].cnt));
            chk($sformatf("v%0d cnt2", i), 32'(o_cnt2), 32'(tbl[i].cnt2));
            chk($sformatf("v%0d pat", i),  32'(o_pat),  32'(tbl[i].epat));
        end
        chk("sat cnt2 final", 32'(o_cnt2), 1);
        chk("det2 follows",   32'(o_det2), 1);

        // ---------------- async reset mid-stream ----------------
        drive(0, 0, 1, 4'b0110, 1, 0);
        @(posedge clk); #1;
        g = 4'b0110;
        for (int b = 0; b < 4; b++) begin
            drive(g[3-b], 1, 0, 4'h0, 1, 0);
            @(posedge clk); #1;
        end
        chk("pre-rst det", 32'(o_det), 1);
        chk("pre-rst cnt", 32'(o_cnt), 2);
        drive(0, 0, 0, 4'h0, 1, 0);
        #2 rst = 1'b1;
        #1;
        chk("async det",  32'(o_det),  0);
        chk("async cnt",  32'(o_cnt),  0);
        chk("async cnt2", 32'(o_cnt2), 0);
        chk("async pat",  32'(o_pat),  32'hB);
        #3 rst = 1'b0;
        // 011 then 1011: single pulse after the final bit
        r = 7'b0111011;
        for (int b = 0; b < 7; b++) begin
            drive(r[6-b], 1, 0, 4'h0, 1, 0);
            @(posedge clk); #1;
            chk($sformatf("post-rst b%0d det", b), 32'(o_det), (b == 6) ? 1 : 0);
        end
        chk("post-rst cnt", 32'(o_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
